// File: rtl/operand_fetch_if.sv
// ============================================================================
// Module   : operand_fetch_if
// Brief    : Decode, register-file read, writeback snoop and execute signals
//            seen by the operand fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface operand_fetch_if #(
    parameter int XLEN = 32
);
    logic            i_dec_valid;
    logic            o_dec_ready;
    logic [4:0]      i_dec_rs1;
    logic            i_dec_rs1_en;
    logic [4:0]      i_dec_rs2;
    logic            i_dec_rs2_en;
    logic [4:0]      i_dec_rd;
    logic            i_dec_rd_en;
    logic [XLEN-1:0] i_dec_pc;

    logic [4:0]      o_rs1_raddr;
    logic [XLEN-1:0] i_rs1_rdata;
    logic [4:0]      o_rs2_raddr;
    logic [XLEN-1:0] i_rs2_rdata;

    logic            i_wb_valid;
    logic [4:0]      i_wb_addr;
    logic [XLEN-1:0] i_wb_data;

    logic            i_flush;

    logic            o_ex_valid;
    logic            i_ex_ready;
    logic [XLEN-1:0] o_ex_rs1_data;
    logic [XLEN-1:0] o_ex_rs2_data;
    logic [4:0]      o_ex_rd;
    logic            o_ex_rd_en;
    logic [XLEN-1:0] o_ex_pc;

    modport slave (
        input  i_dec_valid, i_dec_rs1, i_dec_rs1_en, i_dec_rs2, i_dec_rs2_en,
               i_dec_rd, i_dec_rd_en, i_dec_pc, i_rs1_rdata, i_rs2_rdata,
               i_wb_valid, i_wb_addr, i_wb_data, i_flush, i_ex_ready,
        output o_dec_ready, o_rs1_raddr, o_rs2_raddr, o_ex_valid,
               o_ex_rs1_data, o_ex_rs2_data, o_ex_rd, o_ex_rd_en, o_ex_pc
    );

    modport master (
        output i_dec_valid, i_dec_rs1, i_dec_rs1_en, i_dec_rs2, i_dec_rs2_en,
               i_dec_rd, i_dec_rd_en, i_dec_pc, i_rs1_rdata, i_rs2_rdata,
               i_wb_valid, i_wb_addr, i_wb_data, i_flush, i_ex_ready,
        input  o_dec_ready, o_rs1_raddr, o_rs2_raddr, o_ex_valid,
               o_ex_rs1_data, o_ex_rs2_data, o_ex_rd, o_ex_rd_en, o_ex_pc
    );
endinterface

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// Module   : operand_fetch
// Brief    : Register read stage with busy scoreboard, RAW/WAW stall and
//            writeback bypass, feeding a single-entry execute register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module operand_fetch #(
    parameter int XLEN = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    operand_fetch_if.slave     bus
);
    logic [31:0]     r_busy;
    logic            r_ex_valid;
    logic [XLEN-1:0] r_ex_rs1_data;
    logic [XLEN-1:0] r_ex_rs2_data;
    logic [4:0]      r_ex_rd;
    logic            r_ex_rd_en;
    logic [XLEN-1:0] r_ex_pc;

    logic            w_hazard;
    logic            w_dec_ready;
    logic            w_accept;
    logic            w_issue;
    logic [XLEN-1:0] w_rs1_op;
    logic [XLEN-1:0] w_rs2_op;
    logic [31:0]     w_busy_nxt;

    // A register still has a producer outstanding unless its writeback lands this cycle;
    // the unissued producer in the output register always counts, even while issuing.
    function automatic logic f_pending(
        input logic [4:0]  rs,
        input logic [31:0] busy,
        input logic        wb_valid,
        input logic [4:0]  wb_addr,
        input logic        ex_valid,
        input logic        ex_rd_en,
        input logic [4:0]  ex_rd
    );
        logic sb_hit;
        logic ex_hit;
        sb_hit = busy[rs] && !(wb_valid && (wb_addr == rs));
        ex_hit = ex_valid && ex_rd_en && (ex_rd == rs);
        return (rs != 5'd0) && (sb_hit || ex_hit);
    endfunction

    always_comb begin
        w_hazard =
            (bus.i_dec_rs1_en && f_pending(bus.i_dec_rs1, r_busy, bus.i_wb_valid, bus.i_wb_addr,
                                           r_ex_valid, r_ex_rd_en, r_ex_rd)) ||
            (bus.i_dec_rs2_en && f_pending(bus.i_dec_rs2, r_busy, bus.i_wb_valid, bus.i_wb_addr,
                                           r_ex_valid, r_ex_rd_en, r_ex_rd)) ||
            (bus.i_dec_rd_en  && f_pending(bus.i_dec_rd,  r_busy, bus.i_wb_valid, bus.i_wb_addr,
                                           r_ex_valid, r_ex_rd_en, r_ex_rd));
        w_dec_ready = !w_hazard && !bus.i_flush && (!r_ex_valid || bus.i_ex_ready);
        w_accept    = bus.i_dec_valid && w_dec_ready;
        w_issue     = r_ex_valid && bus.i_ex_ready && !bus.i_flush;

        if (!bus.i_dec_rs1_en || (bus.i_dec_rs1 == 5'd0))
            w_rs1_op = '0;
        else if (bus.i_wb_valid && (bus.i_wb_addr == bus.i_dec_rs1))
            w_rs1_op = bus.i_wb_data;
        else
            w_rs1_op = bus.i_rs1_rdata;

        if (!bus.i_dec_rs2_en || (bus.i_dec_rs2 == 5'd0))
            w_rs2_op = '0;
        else if (bus.i_wb_valid && (bus.i_wb_addr == bus.i_dec_rs2))
            w_rs2_op = bus.i_wb_data;
        else
            w_rs2_op = bus.i_rs2_rdata;

        // Clear first so a same-index set on issue takes priority.
        w_busy_nxt = r_busy;
        if (bus.i_wb_valid && (bus.i_wb_addr != 5'd0))
            w_busy_nxt[bus.i_wb_addr] = 1'b0;
        if (w_issue && r_ex_rd_en && (r_ex_rd != 5'd0))
            w_busy_nxt[r_ex_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy        <= '0;
            r_ex_valid    <= 1'b0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_rd       <= '0;
            r_ex_rd_en    <= 1'b0;
            r_ex_pc       <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (bus.i_flush) begin
                r_ex_valid <= 1'b0;
            end else if (w_accept) begin
                r_ex_valid    <= 1'b1;
                r_ex_rs1_data <= w_rs1_op;
                r_ex_rs2_data <= w_rs2_op;
                r_ex_rd       <= bus.i_dec_rd;
                r_ex_rd_en    <= bus.i_dec_rd_en;
                r_ex_pc       <= bus.i_dec_pc;
            end else if (w_issue) begin
                r_ex_valid <= 1'b0;
            end
        end
    end

    assign bus.o_dec_ready   = w_dec_ready;
    assign bus.o_rs1_raddr   = bus.i_dec_rs1;
    assign bus.o_rs2_raddr   = bus.i_dec_rs2;
    assign bus.o_ex_valid    = r_ex_valid;
    assign bus.o_ex_rs1_data = r_ex_rs1_data;
    assign bus.o_ex_rs2_data = r_ex_rs2_data;
    assign bus.o_ex_rd       = r_ex_rd;
    assign bus.o_ex_rd_en    = r_ex_rd_en;
    assign bus.o_ex_pc       = r_ex_pc;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// Module   : tb_operand_fetch
// Brief    : Directed self-checking bench for operand_fetch.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_operand_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          total = 0;
    int          bad = 0;
    logic [31:0] rf [32];

    operand_fetch_if #(.XLEN(32)) bus ();

    operand_fetch #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.i_rs1_rdata = rf[bus.o_rs1_raddr];
    assign bus.i_rs2_rdata = rf[bus.o_rs2_raddr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic v, input logic [4:0] rs1, input logic e1,
                       input logic [4:0] rs2, input logic e2,
                       input logic [4:0] rd, input logic ed, input logic [31:0] pc);
        bus.i_dec_valid  = v;
        bus.i_dec_rs1    = rs1;
        bus.i_dec_rs1_en = e1;
        bus.i_dec_rs2    = rs2;
        bus.i_dec_rs2_en = e2;
        bus.i_dec_rd     = rd;
        bus.i_dec_rd_en  = ed;
        bus.i_dec_pc     = pc;
        #1;
    endtask

    task automatic wb(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.i_wb_valid = v;
        bus.i_wb_addr  = a;
        bus.i_wb_data  = d;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        rf[3] = 32'h33;
        bus.i_flush    = 1'b0;
        bus.i_ex_ready = 1'b1;
        wb(1'b0, 5'd0, 32'd0);
        dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0);

        // 1: reset state and basic read
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_ex_valid", {31'd0, bus.o_ex_valid}, 32'd0);
        chk("rst_rs1_data", bus.o_ex_rs1_data, 32'd0);
        chk("rst_pc", bus.o_ex_pc, 32'd0);
        chk("rst_rd", {27'd0, bus.o_ex_rd}, 32'd0);
        dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 32'h100);
        chk("t1_ready", {31'd0, bus.o_dec_ready}, 32'd1);
        chk("t1_raddr1", {27'd0, bus.o_rs1_raddr}, 32'd1);
        tick();
        dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0);
        chk("t1_ex_valid", {31'd0, bus.o_ex_valid}, 32'd1);
        chk("t1_rs1", bus.o_ex_rs1_data, 32'd5);
        chk("t1_rs2", bus.o_ex_rs2_data, 32'd7);
        chk("t1_pc", bus.o_ex_pc, 32'h100);
        tick();
        chk("t1_issued", {31'd0, bus.o_ex_valid}, 32'd0);

        // 2: RAW on rd=3 resolved by writeback bypass
        dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 32'h104);
        tick();
        chk("t2_ex_rd", {27'd0, bus.o_ex_rd}, 32'd3);
        dec(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h108);
        chk("t2_stall_exreg", {31'd0, bus.o_dec_ready}, 32'd0);
        tick();
        chk("t2_stall_busy", {31'd0, bus.o_dec_ready}, 32'd0);
        chk("t2_ex_empty", {31'd0, bus.o_ex_valid}, 32'd0);
        tick();
        chk("t2_stall_busy2", {31'd0, bus.o_dec_ready}, 32'd0);
        wb(1'b1, 5'd3, 32'hAA);
        chk("t2_wb_ready", {31'd0, bus.o_dec_ready}, 32'd1);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0);
        chk("t2_ex_valid", {31'd0, bus.o_ex_valid}, 32'd1);
        chk("t2_bypass", bus.o_ex_rs1_data, 32'hAA);
        tick();
        dec(1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0);
        chk("t2_busy_cleared", {31'd0, bus.o_dec_ready}, 32'd1);

        // 3: back-to-back dependency with execute back-pressure
        bus.i_ex_ready = 1'b0;
        dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 32'h10C);
        tick();
        dec(1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 32'h110);
        chk("t3_stall", {31'd0, bus.o_dec_ready}, 32'd0);
        tick();
        chk("t3_held_valid", {31'd0, bus.o_ex_valid}, 32'd1);
        chk("t3_held_rd", {27'd0, bus.o_ex_rd}, 32'd4);
        chk("t3_held_pc", bus.o_ex_pc, 32'h10C);
        chk("t3_stall2", {31'd0, bus.o_dec_ready}, 32'd0);
        dec(1'b0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h110);
        chk("t3_backpressure", {31'd0, bus.o_dec_ready}, 32'd0);
        bus.i_ex_ready = 1'b1;
        dec(1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 32'h110);
        chk("t3_stall_issuing", {31'd0, bus.o_dec_ready}, 32'd0);
        tick();
        dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0);
        wb(1'b1, 5'd4, 32'h44);
        tick();
        wb(1'b0, 5'd0, 32'd0);

        // 4: x0 reads as zero, disabled source reads as zero, rd=0 never busy
        rf[0] = 32'h1;
        dec(1'b1, 5'd0, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 32'h114);
        chk("t4_ready", {31'd0, bus.o_dec_ready}, 32'd1);
        tick();
        dec(1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 32'h118);
        chk("t4_x0_zero", bus.o_ex_rs1_data, 32'd0);
        chk("t4_rs2", bus.o_ex_rs2_data, 32'd7);
        chk("t4_rd_en", {31'd0, bus.o_ex_rd_en}, 32'd1);
        chk("t4_rd0_no_stall", {31'd0, bus.o_dec_ready}, 32'd1);
        tick();
        dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0);
        chk("t4_disabled_src", bus.o_ex_rs1_data, 32'd0);
        tick();

        // 5: flush keeps busy bits, reset mid-stall clears everything
        dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 32'h11C);
        tick();
        dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0);
        tick();
        bus.i_ex_ready = 1'b0;
        dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 32'h120);
        tick();
        dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0);
        chk("t5_held", {31'd0, bus.o_ex_valid}, 32'd1);
        bus.i_flush    = 1'b1;
        bus.i_ex_ready = 1'b1;
        #1;
        chk("t5_flush_ready", {31'd0, bus.o_dec_ready}, 32'd0);
        tick();
        bus.i_flush = 1'b0;
        #1;
        chk("t5_flushed", {31'd0, bus.o_ex_valid}, 32'd0);
        dec(1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0);
        chk("t5_busy_kept", {31'd0, bus.o_dec_ready}, 32'd0);
        dec(1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0);
        chk("t5_no_busy_set", {31'd0, bus.o_dec_ready}, 32'd1);
        dec(1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 32'h124);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dec(1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0);
        chk("t5_rst_valid", {31'd0, bus.o_ex_valid}, 32'd0);
        chk("t5_rst_pc", bus.o_ex_pc, 32'd0);
        chk("t5_rst_rs2", bus.o_ex_rs2_data, 32'd0);
        chk("t5_rst_busy", {31'd0, bus.o_dec_ready}, 32'd1);

        // 6: WAW on rd=5
        dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 32'h200);
        tick();
        dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 32'h204);
        chk("t6_waw_exreg", {31'd0, bus.o_dec_ready}, 32'd0);
        tick();
        chk("t6_waw_busy", {31'd0, bus.o_dec_ready}, 32'd0);
        tick();
        chk("t6_waw_busy2", {31'd0, bus.o_dec_ready}, 32'd0);
        wb(1'b1, 5'd5, 32'h55);
        chk("t6_wb_ready", {31'd0, bus.o_dec_ready}, 32'd1);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0);
        chk("t6_ex_valid", {31'd0, bus.o_ex_valid}, 32'd1);
        chk("t6_ex_rd", {27'd0, bus.o_ex_rd}, 32'd5);
        chk("t6_ex_pc", bus.o_ex_pc, 32'h204);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
